// File: rtl/frame_sequencer_if.sv
// Column-slice fetch handshake plus the pixel write port toward the frame buffer.
// master = frame_sequencer side, slave = raycast datapath / frame buffer side.
interface frame_sequencer_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
) ();
  logic               slice_req;
  logic [X_W-1:0]     slice_col;
  logic               slice_valid;
  logic [Y_W:0]       slice_height;
  logic [COLOR_W-1:0] slice_color;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color_out;
  logic               draw_enable;

  modport master (
    output slice_req, slice_col, x, y, color_out, draw_enable,
    input  slice_valid, slice_height, slice_color
  );

  modport slave (
    input  slice_req, slice_col, x, y, color_out, draw_enable,
    output slice_valid, slice_height, slice_color
  );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer: one frame per rising edge of frame_tick. Optionally clears the
// whole screen, then fetches one wall slice per column and draws it vertically
// centred (clear mode) or fills ceiling/wall/floor for every row (fill mode).
module frame_sequencer #(
  parameter int H_RES       = 160,
  parameter int V_RES       = 120,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOR_W     = 3,
  parameter int CLEAR_COLOR = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               mode_clear,
  input  logic [COLOR_W-1:0] ceil_color,
  input  logic [COLOR_W-1:0] floor_color,
  frame_sequencer_if.master  bus,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  typedef enum logic [2:0] {IDLE, CLEAR, REQ, COLUMN, DONE} state_t;

  localparam logic [X_W-1:0]     COL_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]     ROW_LAST = Y_W'(V_RES - 1);
  localparam logic [Y_W:0]       V_RES_H  = (Y_W+1)'(V_RES);
  localparam logic [Y_W:0]       ONE_H    = (Y_W+1)'(1);
  localparam logic [X_W-1:0]     ONE_X    = X_W'(1);
  localparam logic [Y_W-1:0]     ONE_Y    = Y_W'(1);
  localparam logic [COLOR_W-1:0] CLEAR_C  = COLOR_W'(CLEAR_COLOR);

  state_t             state_reg, state_next;
  logic               tick_reg;
  logic               mode_reg, mode_next;
  logic [COLOR_W-1:0] ceil_reg, ceil_next;
  logic [COLOR_W-1:0] floor_reg, floor_next;
  logic [COLOR_W-1:0] wall_color_reg, wall_color_next;
  logic [X_W-1:0]     col_reg, col_next;
  logic [Y_W-1:0]     row_reg, row_next;
  // top_reg is the first wall row, end_reg is one past the last wall row;
  // end_reg == top_reg marks an empty (h = 0) slice without needing top-1.
  logic [Y_W:0]       top_reg, top_next;
  logic [Y_W:0]       end_reg, end_next;
  logic               overrun_reg, overrun_next;

  logic               start;
  logic [Y_W:0]       h_clamp;
  logic [Y_W:0]       top_calc;
  logic [Y_W:0]       row_ext;
  logic               column_last;

  // Rising-edge detect on the tick plus slice geometry from the incoming height.
  always_comb begin
    start    = frame_tick & ~tick_reg;
    h_clamp  = (bus.slice_height > V_RES_H) ? V_RES_H : bus.slice_height;
    top_calc = (V_RES_H - h_clamp) >> 1;
    row_ext  = {1'b0, row_reg};
    if (mode_reg) begin
      column_last = (end_reg == top_reg) || ((row_ext + ONE_H) == end_reg);
    end else begin
      column_last = (row_reg == ROW_LAST);
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_next      = state_reg;
    mode_next       = mode_reg;
    ceil_next       = ceil_reg;
    floor_next      = floor_reg;
    wall_color_next = wall_color_reg;
    col_next        = col_reg;
    row_next        = row_reg;
    top_next        = top_reg;
    end_next        = end_reg;
    overrun_next    = start && (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next  = mode_clear;
          ceil_next  = ceil_color;
          floor_next = floor_color;
          col_next   = '0;
          row_next   = '0;
          state_next = mode_clear ? CLEAR : REQ;
        end
      end
      CLEAR: begin
        if (col_reg == COL_LAST) begin
          col_next = '0;
          if (row_reg == ROW_LAST) begin
            row_next   = '0;
            state_next = REQ;
          end else begin
            row_next = row_reg + ONE_Y;
          end
        end else begin
          col_next = col_reg + ONE_X;
        end
      end
      REQ: begin
        if (bus.slice_valid) begin
          wall_color_next = bus.slice_color;
          top_next        = top_calc;
          end_next        = top_calc + h_clamp;
          row_next        = mode_reg ? top_calc[Y_W-1:0] : '0;
          state_next      = COLUMN;
        end
      end
      COLUMN: begin
        if (column_last) begin
          row_next = '0;
          if (col_reg == COL_LAST) begin
            state_next = DONE;
          end else begin
            col_next   = col_reg + ONE_X;
            state_next = REQ;
          end
        end else begin
          row_next = row_reg + ONE_Y;
        end
      end
      DONE: begin
        col_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from registered state and counters only.
  always_comb begin
    bus.slice_req   = 1'b0;
    bus.slice_col   = '0;
    bus.x           = '0;
    bus.y           = '0;
    bus.color_out   = '0;
    bus.draw_enable = 1'b0;
    busy            = (state_reg != IDLE);
    frame_done      = (state_reg == DONE);
    overrun         = overrun_reg;

    case (state_reg)
      CLEAR: begin
        bus.x           = col_reg;
        bus.y           = row_reg;
        bus.color_out   = CLEAR_C;
        bus.draw_enable = 1'b1;
      end
      REQ: begin
        bus.slice_req = 1'b1;
        bus.slice_col = col_reg;
      end
      COLUMN: begin
        bus.slice_col = col_reg;
        bus.x         = col_reg;
        bus.y         = row_reg;
        if (mode_reg) begin
          bus.draw_enable = (end_reg != top_reg);
          bus.color_out   = wall_color_reg;
        end else begin
          bus.draw_enable = 1'b1;
          if (row_ext < top_reg) begin
            bus.color_out = ceil_reg;
          end else if (row_ext < end_reg) begin
            bus.color_out = wall_color_reg;
          end else begin
            bus.color_out = floor_reg;
          end
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; tick history resets high so a tick already
  // asserted at reset release is not mistaken for a new frame request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      tick_reg       <= 1'b1;
      mode_reg       <= 1'b0;
      ceil_reg       <= '0;
      floor_reg      <= '0;
      wall_color_reg <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      top_reg        <= '0;
      end_reg        <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tick_reg       <= frame_tick;
      mode_reg       <= mode_next;
      ceil_reg       <= ceil_next;
      floor_reg      <= floor_next;
      wall_color_reg <= wall_color_next;
      col_reg        <= col_next;
      row_reg        <= row_next;
      top_reg        <= top_next;
      end_reg        <= end_next;
      overrun_reg    <= overrun_next;
    end
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Parametrised successor to the 160x120 frame clear/draw controller.
- Sequences one frame per rising edge of a frame tick and emits pixel writes (x, y, color, draw_enable) to the vga_adapter frame buffer.
- Fetches each column slice (wall height and colour) from the raycast datapath over a req/valid handshake, then centres the wall vertically.
- Two modes: separate full-screen clear pass followed by wall-only drawing, or a single pass that fills ceiling, wall and floor per column.

Parameters:
- H_RES, 160, columns per frame.
- V_RES, 120, rows per frame.
- X_W, 8, width of x and column index; must satisfy 2^X_W >= H_RES.
- Y_W, 7, width of y; must satisfy 2^Y_W >= V_RES.
- COLOR_W, 3, pixel colour width.
- CLEAR_COLOR, 0, colour written during the clear pass.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  frame-rate level signal, synchronous to clock; each rising edge requests a frame.
- mode_clear  in  1  1 = clear pass, then wall-only columns; 0 = per-column ceiling/wall/floor fill. Sampled at frame start.
- ceil_color  in  COLOR_W  ceiling colour (fill mode), sampled at frame start.
- floor_color  in  COLOR_W  floor colour (fill mode), sampled at frame start.
- slice_req  out  1  request for the slice of column slice_col.
- slice_col  out  X_W  column being requested or drawn.
- slice_valid  in  1  slice_height/slice_color valid; accepted while slice_req=1.
- slice_height  in  Y_W+1  wall height in pixels.
- slice_color  in  COLOR_W  wall colour.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- color_out  out  COLOR_W  pixel colour.
- draw_enable  out  1  frame-buffer write enable.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.
- overrun  out  1  one-cycle pulse when a tick edge arrives while busy.

Behaviour:
- Interface (already decided): one clock `clock`; reset `reset` is asynchronous and active-high.
- Reset:
  - state=IDLE; all outputs 0; column and row counters 0.
  - tick_q resets to 1, so frame_tick already high at reset release does not start a frame.
  - Reset asserted mid-frame aborts the frame immediately; no frame_done is issued.
- Start: start = frame_tick & ~tick_q (tick_q is frame_tick registered).
  - In IDLE, start latches mode_clear, ceil_color and floor_color.
  - Next state is CLEAR if mode_clear=1, else REQ with column=0.
- Overrun: start while not in IDLE → overrun=1 for that cycle. The current frame is unaffected and the edge is dropped.
- States: IDLE, CLEAR, REQ, COLUMN, DONE.
- CLEAR:
  - Raster scan, one pixel per cycle: x inner 0..H_RES-1, y outer 0..V_RES-1.
  - draw_enable=1, color_out=CLEAR_COLOR.
  - First pixel (0,0) is in the first CLEAR cycle.
  - Lasts exactly H_RES*V_RES cycles, then REQ with column=0.
- REQ:
  - slice_req=1, slice_col=column, draw_enable=0; held indefinitely until slice_valid.
  - On slice_valid (same-cycle acceptance): capture color and h = min(slice_height, V_RES).
  - Compute top = (V_RES-h)>>1, bot = top+h-1, then go to COLUMN.
- COLUMN, x=column:
  - Clear mode: y steps top..bot, one cycle each, color_out=slice color, draw_enable=1. If h=0, COLUMN lasts 1 cycle with draw_enable=0.
  - Fill mode: y steps 0..V_RES-1. color_out is ceil_color for y<top, slice color for top<=y<=bot, floor_color for y>bot. draw_enable=1 every cycle.
  - After the last row: if column=H_RES-1 go to DONE; else column+1 and go to REQ.
- DONE: frame_done=1 for one cycle, then IDLE.
- Outputs in IDLE/DONE: x, y, color_out, draw_enable are 0.
- Output timing: all outputs are decoded from registered state and counters, with no input-to-output combinational path except that slice_req deasserts the cycle after acceptance.
- Arithmetic: counters wrap only via explicit terminal compares; no modular wrap is relied on.

Test Plan:
- Reset: H_RES=4, V_RES=6. Hold frame_tick=1 through reset release → no frame. Assert reset during COLUMN → draw_enable, busy, slice_req go 0 without waiting for a clock edge; no frame_done.
- Clear mode, 4x6, CLEAR_COLOR=0, tick edge → 24 consecutive draw_enable cycles over (0,0),(1,0)..(3,5), then slice_req=1, slice_col=0.
- Centring, clear mode, V_RES=6:
  - h=2 → y=2,3.
  - h=3 → y=1..3.
  - h=9 (clamped) → y=0..5.
  - h=0 → no write, next slice_req with slice_col+1.
- Fill mode: ceil=1, floor=2, slice_color=5, h=2 → column writes y0=1, y1=1, y2=5, y3=5, y4=2, y5=2; no clear pass.
- Stall: slice_valid withheld 10 cycles → slice_req stays 1, slice_col stable, draw_enable=0. Frame completes correctly afterwards.
- Overrun/done: second tick edge during column 1 → overrun single pulse and frame continues. frame_done single pulse after column 3, then busy=0.
